// File: rtl/rect_filler.sv
// Rectangle fill engine: clips an inclusive pixel rectangle to the frame and writes it as
// 8-pixel two-beat bursts to the DDR2 address / write-data FIFOs, byte-masking partial edges.
module rect_filler #(
    parameter int unsigned FRAME_W = 800,
    parameter int unsigned FRAME_H = 600,
    parameter int unsigned X_BITS  = 10,
    parameter int unsigned Y_BITS  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [23:0]       color,
    input  logic [X_BITS-1:0] x0,
    input  logic [X_BITS-1:0] x1,
    input  logic [Y_BITS-1:0] y0,
    input  logic [Y_BITS-1:0] y1,
    input  logic [31:0]       frame_base,
    input  logic              af_full,
    input  logic              wdf_full,
    output logic [30:0]       af_addr_din,
    output logic              af_wr_en,
    output logic [127:0]      wdf_din,
    output logic [15:0]       wdf_mask_din,
    output logic              wdf_wr_en,
    output logic              ready,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StCmd, StBeat2} state_e;

    state_e            state_q;
    logic [23:0]       color_q;
    logic [5:0]        fb_q;
    logic [X_BITS-1:0] x0_q, x1_q, bx_q;
    logic [Y_BITS-1:0] y_q, y1_q;
    logic              done_q;

    logic [X_BITS-1:0] x1_clip;
    logic [Y_BITS-1:0] y1_clip;
    logic              cmd_empty;
    logic              last_col;
    logic              last_row;
    logic              unused_fb;

    assign unused_fb = ^{frame_base[31:28], frame_base[21:0]};

    assign x1_clip = (32'(x1) > FRAME_W - 1) ? X_BITS'(FRAME_W - 1) : x1;
    assign y1_clip = (32'(y1) > FRAME_H - 1) ? Y_BITS'(FRAME_H - 1) : y1;

    assign cmd_empty = (x0 > x1_clip) || (y0 > y1_clip) ||
                       (32'(x0) >= FRAME_W) || (32'(y0) >= FRAME_H);

    // One extra bit so bx+8 cannot wrap at the top of the coordinate range.
    assign last_col = ({1'b0, bx_q} + (X_BITS+1)'(8)) > {1'b0, x1_q};
    assign last_row = (y_q == y1_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            color_q <= '0;
            fb_q    <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            bx_q    <= '0;
            y_q     <= '0;
            y1_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (valid) begin
                        color_q <= color;
                        fb_q    <= frame_base[27:22];
                        x0_q    <= x0;
                        x1_q    <= x1_clip;
                        y1_q    <= y1_clip;
                        bx_q    <= {x0[X_BITS-1:3], 3'b000};
                        y_q     <= y0;
                        if (cmd_empty) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= StCmd;
                        end
                    end
                end
                StCmd: begin
                    if (!af_full && !wdf_full) begin
                        state_q <= StBeat2;
                    end
                end
                StBeat2: begin
                    if (!wdf_full) begin
                        if (last_col) begin
                            bx_q <= {x0_q[X_BITS-1:3], 3'b000};
                            if (last_row) begin
                                state_q <= StIdle;
                                done_q  <= 1'b1;
                            end else begin
                                y_q     <= y_q + Y_BITS'(1);
                                state_q <= StCmd;
                            end
                        end else begin
                            bx_q    <= bx_q + X_BITS'(8);
                            state_q <= StCmd;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready       = (state_q == StIdle);
    assign done        = done_q;
    assign af_wr_en    = (state_q == StCmd) && !af_full && !wdf_full;
    assign wdf_wr_en   = af_wr_en || ((state_q == StBeat2) && !wdf_full);
    assign af_addr_din = 31'({fb_q, y_q, bx_q[X_BITS-1:3], 2'b00});
    assign wdf_din     = {4{{8'd0, color_q}}};

    // Beat 0 covers bx..bx+3, beat 1 covers bx+4..bx+7; everything is masked while idle.
    always_comb begin
        logic [X_BITS:0] col;
        col          = '0;
        wdf_mask_din = 16'hFFFF;
        if (state_q != StIdle) begin
            for (int k = 0; k < 4; k++) begin
                col = {1'b0, bx_q} + (X_BITS+1)'(k) +
                      ((state_q == StBeat2) ? (X_BITS+1)'(4) : (X_BITS+1)'(0));
                wdf_mask_din[4*k +: 4] = ((col < {1'b0, x0_q}) || (col > {1'b0, x1_q})) ?
                                         4'hF : 4'h0;
            end
        end
    end

endmodule
